// File: rtl/uart_trx.sv
`default_nettype none
// ============================================================================
// Module  : uart_trx
// Brief   : Parametrised full-duplex UART (5..9 data bits, none/odd/even
//           parity, 1/2 stop bits) with valid/ready handshakes on TX and RX.
// Rev     : 1.0  initial release
// ============================================================================
module uart_trx #(
  parameter int CLK_DIV   = 434,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 rs232_tx,
  input  logic                 rs232_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam logic [15:0] c_bit_end   = 16'(CLK_DIV - 1);
  localparam logic [15:0] c_bit_mid   = 16'(CLK_DIV / 2);
  localparam logic [3:0]  c_last_data = 4'(DATA_BITS - 1);
  localparam logic [3:0]  c_last_stop = 4'(STOP_BITS - 1);
  localparam logic        c_par_en    = (PARITY != 0);
  localparam logic        c_par_odd   = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // ------------------------------------------------------------------ TX
  state_t               r_tx_state, w_tx_state_nxt;
  logic [15:0]          r_tx_cnt;
  logic [3:0]           r_tx_bit;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx_par;
  logic                 r_tx_line;
  logic                 w_tx_tick;
  logic                 w_tx_accept;

  assign w_tx_tick   = (r_tx_cnt == c_bit_end);
  assign tx_ready    = (r_tx_state == S_IDLE);
  assign w_tx_accept = tx_valid && tx_ready;
  assign rs232_tx    = r_tx_line;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_tx_state <= S_IDLE;
    else        r_tx_state <= w_tx_state_nxt;
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    case (r_tx_state)
      S_IDLE:   if (tx_valid) w_tx_state_nxt = S_START;
      S_START:  if (w_tx_tick) w_tx_state_nxt = S_DATA;
      S_DATA:   if (w_tx_tick && (r_tx_bit == c_last_data))
                  w_tx_state_nxt = c_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (w_tx_tick) w_tx_state_nxt = S_STOP;
      S_STOP:   if (w_tx_tick && (r_tx_bit == c_last_stop)) w_tx_state_nxt = S_IDLE;
      default:  w_tx_state_nxt = S_IDLE;
    endcase
  end

  // The line register is loaded with the value of the upcoming bit at each bit boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_tx_line  <= 1'b1;
    end else if (r_tx_state == S_IDLE) begin
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
      if (w_tx_accept) begin
        r_tx_shift <= tx_data;
        r_tx_par   <= (^tx_data) ^ c_par_odd;
        r_tx_line  <= 1'b0;
      end
    end else if (!w_tx_tick) begin
      r_tx_cnt <= r_tx_cnt + 16'd1;
    end else begin
      r_tx_cnt <= '0;
      case (r_tx_state)
        S_START: begin
          r_tx_line <= r_tx_shift[0];
          r_tx_bit  <= '0;
        end
        S_DATA: begin
          r_tx_shift <= r_tx_shift >> 1;
          if (r_tx_bit == c_last_data) begin
            r_tx_bit  <= '0;
            r_tx_line <= c_par_en ? r_tx_par : 1'b1;
          end else begin
            r_tx_bit  <= r_tx_bit + 4'd1;
            r_tx_line <= r_tx_shift[1];
          end
        end
        S_PARITY: begin
          r_tx_line <= 1'b1;
          r_tx_bit  <= '0;
        end
        default: begin
          r_tx_line <= 1'b1;
          r_tx_bit  <= r_tx_bit + 4'd1;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------ RX
  logic                 r_rx_meta, r_rx_sync, r_rx_prev;
  state_t               r_rx_state, w_rx_state_nxt;
  logic [15:0]          r_rx_cnt;
  logic [3:0]           r_rx_bit;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_par_bit;
  logic                 w_rx_fall, w_rx_mid, w_rx_end, w_rx_done, w_rx_perr;

  // Synchroniser idles high so that reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rs232_rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_rx_fall = r_rx_prev & ~r_rx_sync;
  assign w_rx_mid  = (r_rx_cnt == c_bit_mid);
  assign w_rx_end  = (r_rx_cnt == c_bit_end);
  assign w_rx_done = (r_rx_state == S_STOP) && w_rx_mid;
  assign w_rx_perr = c_par_en & ((^r_rx_shift) ^ r_rx_par_bit ^ c_par_odd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rx_state <= S_IDLE;
    else        r_rx_state <= w_rx_state_nxt;
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    case (r_rx_state)
      S_IDLE:   if (w_rx_fall) w_rx_state_nxt = S_START;
      S_START:  if (w_rx_mid && r_rx_sync) w_rx_state_nxt = S_IDLE;
                else if (w_rx_end) w_rx_state_nxt = S_DATA;
      S_DATA:   if (w_rx_end && (r_rx_bit == c_last_data))
                  w_rx_state_nxt = c_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (w_rx_end) w_rx_state_nxt = S_STOP;
      S_STOP:   if (w_rx_mid) w_rx_state_nxt = S_IDLE;
      default:  w_rx_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_cnt     <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
      r_rx_par_bit <= 1'b0;
    end else if (r_rx_state == S_IDLE) begin
      r_rx_cnt <= '0;
      r_rx_bit <= '0;
    end else begin
      r_rx_cnt <= w_rx_end ? 16'd0 : r_rx_cnt + 16'd1;
      if (w_rx_mid && (r_rx_state == S_DATA))
        r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
      if (w_rx_mid && (r_rx_state == S_PARITY))
        r_rx_par_bit <= r_rx_sync;
      if (w_rx_end && (r_rx_state == S_DATA))
        r_rx_bit <= r_rx_bit + 4'd1;
    end
  end

  // A finished frame is dropped only while an unread word is held back by the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_overrun <= w_rx_done && rx_valid && !rx_ready;
      if (w_rx_done && (!rx_valid || rx_ready)) begin
        rx_data       <= r_rx_shift;
        rx_parity_err <= w_rx_perr;
        rx_frame_err  <= ~r_rx_sync;
        rx_valid      <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_trx.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_trx
// Brief   : Scoreboard bench for uart_trx in 8N1, 8E1 and 7O2 builds.
// Rev     : 1.0  initial release
// ============================================================================
module tb_uart_trx;

  localparam int CLK_DIV = 16;
  localparam int N       = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Frame format per instance: 0 = 8N1, 1 = 8E1, 2 = 7O2
  int db  [N] = '{8, 8, 7};
  int par [N] = '{0, 2, 1};
  int sb  [N] = '{1, 1, 2};

  logic [8:0]   tx_d [N];
  logic [N-1:0] tx_valid, rx_ready, loop_en, drv_line;
  logic [N-1:0] rx_line;
  wire  [N-1:0] tx_ready, tx_line, rx_valid, perr, ferr, ovr;
  wire  [7:0]   rx_data0, rx_data1;
  wire  [6:0]   rx_data2;

  assign rx_line = (loop_en & tx_line) | (~loop_en & drv_line);

  uart_trx #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n81 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_d[0][7:0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .rs232_tx(tx_line[0]), .rs232_rx(rx_line[0]),
    .rx_data(rx_data0), .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]),
    .rx_parity_err(perr[0]), .rx_frame_err(ferr[0]), .rx_overrun(ovr[0]));

  uart_trx #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_e81 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_d[1][7:0]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .rs232_tx(tx_line[1]), .rs232_rx(rx_line[1]),
    .rx_data(rx_data1), .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]),
    .rx_parity_err(perr[1]), .rx_frame_err(ferr[1]), .rx_overrun(ovr[1]));

  uart_trx #(.CLK_DIV(CLK_DIV), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_o72 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_d[2][6:0]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .rs232_tx(tx_line[2]), .rs232_rx(rx_line[2]),
    .rx_data(rx_data2), .rx_valid(rx_valid[2]), .rx_ready(rx_ready[2]),
    .rx_parity_err(perr[2]), .rx_frame_err(ferr[2]), .rx_overrun(ovr[2]));

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int rx_word(input int i);
    case (i)
      0:       return int'(rx_data0);
      1:       return int'(rx_data1);
      default: return int'(rx_data2);
    endcase
  endfunction

  // ---------------------------------------------------------------- model
  typedef struct { int inst; int n; logic [15:0] bits; int gap; } tx_item_t;
  typedef struct { int inst; int data; int perr; int ferr; } rx_item_t;
  tx_item_t tx_q [$];
  rx_item_t rx_q [$];

  // Wire image of one frame, index 0 first on the line.
  function automatic logic [15:0] frame_bits(input int i, input int w, output int n);
    logic [15:0] b;
    int k, ones;
    b = '0;
    ones = 0;
    k = 1;
    for (int j = 0; j < db[i]; j++) begin
      b[k] = w[j];
      ones += w[j] ? 1 : 0;
      k++;
    end
    if (par[i] == 1) begin b[k] = (ones % 2 == 0); k++; end
    if (par[i] == 2) begin b[k] = (ones % 2 == 1); k++; end
    for (int j = 0; j < sb[i]; j++) begin b[k] = 1'b1; k++; end
    n = k;
    return b;
  endfunction

  // ---------------------------------------------------------------- stimulus helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int c);
    repeat (c) tick();
  endtask

  task automatic exp_rx(input int i, input int w, input int pe, input int fe);
    rx_item_t it;
    it.inst = i; it.data = w; it.perr = pe; it.ferr = fe;
    rx_q.push_back(it);
  endtask

  task automatic tx_send(input int i, input int w, input int gap);
    tx_item_t it;
    int t;
    it.inst = i;
    it.gap  = gap;
    it.bits = frame_bits(i, w, it.n);
    t = 0;
    while (!tx_ready[i] && t < 2000) begin tick(); t++; end
    check("tx_ready_before_send", int'(tx_ready[i]), 1);
    tx_q.push_back(it);
    tx_d[i] = 9'(w);
    tx_valid[i] = 1'b1;
    tick();
    tx_valid[i] = 1'b0;
  endtask

  task automatic wait_tx_idle(input int i);
    int t;
    t = 0;
    while (!tx_ready[i] && t < 2000) begin tick(); t++; end
    check("tx_idle_timeout", int'(tx_ready[i]), 1);
  endtask

  task automatic line_send(input int i, input logic [15:0] bits, input int n);
    for (int k = 0; k < n; k++) begin
      drv_line[i] = bits[k];
      idle(CLK_DIV);
    end
    drv_line[i] = 1'b1;
  endtask

  // ---------------------------------------------------------------- monitors
  initial begin : tx_mon
    tx_item_t it;
    int w;
    logic ok;
    forever begin
      if (tx_q.size() == 0) begin
        @(negedge clk);
      end else begin
        it = tx_q.pop_front();
        w = 0;
        while (tx_line[it.inst] !== 1'b0 && w < 4000) begin @(negedge clk); w++; end
        check("tx_start_seen", int'(w < 4000), 1);
        if (it.gap >= 0) check("tx_back_to_back_gap", w, it.gap);
        for (int k = 0; k < it.n; k++) begin
          ok = 1'b1;
          for (int c = 0; c < CLK_DIV; c++) begin
            if (tx_line[it.inst] !== it.bits[k]) ok = 1'b0;
            @(negedge clk);
          end
          check($sformatf("tx%0d_bit%0d_stable_16", it.inst, k), int'(ok), 1);
        end
      end
    end
  end

  int vcnt [N];
  int ocnt [N];

  initial begin : rx_mon
    rx_item_t it;
    for (int i = 0; i < N; i++) begin vcnt[i] = 0; ocnt[i] = 0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (rx_valid[i]) vcnt[i]++;
        if (ovr[i]) ocnt[i]++;
        if (rx_valid[i] && rx_ready[i]) begin
          if (rx_q.size() == 0) begin
            check($sformatf("rx%0d_unexpected_word", i), rx_word(i), -1);
          end else begin
            it = rx_q.pop_front();
            check("rx_instance", i, it.inst);
            check($sformatf("rx%0d_data", i), rx_word(i), it.data);
            check($sformatf("rx%0d_parity_err", i), int'(perr[i]), it.perr);
            check($sformatf("rx%0d_frame_err", i), int'(ferr[i]), it.ferr);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- main sequence
  initial begin : stim
    int v0, o0, w, n;
    logic [15:0] bits;

    tx_valid = '0; rx_ready = '0; loop_en = '0; drv_line = '1;
    for (int i = 0; i < N; i++) tx_d[i] = '0;

    // Reset values, held and after release
    idle(5);
    check("rst_tx_line", int'(tx_line), 3'b111);
    check("rst_tx_ready", int'(tx_ready), 3'b111);
    check("rst_rx_valid", int'(rx_valid), 0);
    check("rst_err_flags", int'({perr, ferr, ovr}), 0);
    check("rst_rx_data", rx_word(0) | rx_word(1) | rx_word(2), 0);
    rst_n = 1'b1;
    idle(100);
    check("idle_tx_line", int'(tx_line), 3'b111);
    check("idle_tx_ready", int'(tx_ready), 3'b111);
    check("idle_rx_valid", int'(rx_valid), 0);

    // 8N1 TX: 0xA5, ready-low length, then back-to-back and random words
    tx_send(0, 8'hA5, -1);
    n = 0;
    while (!tx_ready[0] && n < 1000) begin n++; tick(); end
    check("tx_ready_low_cycles", n, 160);
    tx_send(0, int'($urandom_range(0, 255)), 1);
    for (int r = 0; r < 3; r++) begin
      idle(int'($urandom_range(0, 40)));
      tx_send(0, int'($urandom_range(0, 255)), -1);
    end
    wait_tx_idle(0);
    idle(5);

    // 8E1 loopback
    loop_en[1] = 1'b1; rx_ready[1] = 1'b1;
    v0 = vcnt[1];
    exp_rx(1, 8'h3C, 0, 0);
    tx_send(1, 8'h3C, -1);
    for (int r = 0; r < 3; r++) begin
      w = int'($urandom_range(0, 255));
      exp_rx(1, w, 0, 0);
      tx_send(1, w, -1);
    end
    wait_tx_idle(1);
    idle(40);
    check("e81_loop_valid_cycles", vcnt[1] - v0, 4);
    loop_en[1] = 1'b0;

    // 7O2 loopback
    loop_en[2] = 1'b1; rx_ready[2] = 1'b1;
    v0 = vcnt[2];
    exp_rx(2, 7'h55, 0, 0);
    tx_send(2, 7'h55, -1);
    for (int r = 0; r < 3; r++) begin
      w = int'($urandom_range(0, 127));
      exp_rx(2, w, 0, 0);
      tx_send(2, w, -1);
    end
    wait_tx_idle(2);
    idle(40);
    check("o72_loop_valid_cycles", vcnt[2] - v0, 4);
    loop_en[2] = 1'b0;
    idle(20);

    // 8E1 error injection: bad parity, then stop bit low with data 0x00
    bits = frame_bits(1, 8'h3C, n);
    bits[9] = ~bits[9];
    exp_rx(1, 8'h3C, 1, 0);
    line_send(1, bits, n);
    idle(20);
    bits = frame_bits(1, 0, n);
    bits[10] = 1'b0;
    exp_rx(1, 0, 0, 1);
    line_send(1, bits, n);
    idle(20);

    // Random externally driven 7O2 frames
    for (int r = 0; r < 3; r++) begin
      w = int'($urandom_range(0, 127));
      exp_rx(2, w, 0, 0);
      bits = frame_bits(2, w, n);
      line_send(2, bits, n);
      idle(int'($urandom_range(0, 20)));
    end
    idle(20);

    // Overrun on 8N1: second word dropped while the first is unread
    rx_ready[0] = 1'b0;
    o0 = ocnt[0];
    exp_rx(0, 8'h11, 0, 0);
    bits = frame_bits(0, 8'h11, n);
    line_send(0, bits, n);
    idle(10);
    bits = frame_bits(0, 8'h22, n);
    line_send(0, bits, n);
    idle(10);
    check("overrun_pulse_cycles", ocnt[0] - o0, 1);
    check("overrun_held_data", rx_word(0), 8'h11);
    check("overrun_held_valid", int'(rx_valid[0]), 1);
    rx_ready[0] = 1'b1;
    idle(3);
    check("overrun_valid_cleared", int'(rx_valid[0]), 0);

    // Glitch: 3-cycle low pulse produces nothing, next frame still decodes
    v0 = vcnt[0];
    o0 = ocnt[0];
    drv_line[0] = 1'b0;
    idle(3);
    drv_line[0] = 1'b1;
    idle(60);
    check("glitch_no_valid", vcnt[0] - v0, 0);
    check("glitch_no_overrun", ocnt[0] - o0, 0);
    w = int'($urandom_range(0, 255));
    exp_rx(0, w, 0, 0);
    bits = frame_bits(0, w, n);
    line_send(0, bits, n);
    idle(20);
    check("post_glitch_valid", vcnt[0] - v0, 1);

    // Mid-frame reset during TX bit 4
    tx_d[0] = '0;
    tx_valid[0] = 1'b1;
    tick();
    tx_valid[0] = 1'b0;
    idle(4 * CLK_DIV + 8);
    check("txrst_line_low_before", int'(tx_line[0]), 0);
    #2 rst_n = 1'b0;
    #1;
    check("txrst_line_high_async", int'(tx_line[0]), 1);
    check("txrst_ready_async", int'(tx_ready[0]), 1);
    idle(3);
    rst_n = 1'b1;
    idle(5);

    // Mid-frame reset during RX bit 4
    drv_line[0] = 1'b0;
    idle(5 * CLK_DIV);
    #2 rst_n = 1'b0;
    #1;
    check("rxrst_valid", int'(rx_valid[0]), 0);
    drv_line[0] = 1'b1;
    idle(5);
    rst_n = 1'b1;
    idle(20);
    v0 = vcnt[0];
    w = int'($urandom_range(0, 255));
    exp_rx(0, w, 0, 0);
    bits = frame_bits(0, w, n);
    line_send(0, bits, n);
    idle(20);
    check("post_reset_rx_valid", vcnt[0] - v0, 1);
    tx_send(0, int'($urandom_range(0, 255)), -1);
    wait_tx_idle(0);
    idle(20);

    check("tx_queue_drained", tx_q.size(), 0);
    check("rx_queue_drained", rx_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_trx.md
Name: uart_trx

Overview:
- Parametrised full-duplex UART transceiver; next generation of the fixed 8N1 echo-pair built from speed-select, rx and tx blocks.
- Generalised in frame format (data bits, parity, stop bits) and baud divisor.
- Independent valid/ready handshakes on TX and RX; RX reports parity, framing and overrun errors.
- Sits between a peripheral register wrapper (mclk/puc_rst domain, reset inverted at instantiation) and the rs232 pins.

Parameters:
- CLK_DIV, 434, mclk cycles per bit; legal range 8..65535.
- DATA_BITS, 8, payload bits per frame; legal range 5..9; sent LSB first.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits per frame: 1 or 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- tx_data  in  DATA_BITS  byte to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  TX idle and able to accept.
- rs232_tx  out  1  serial output, idle high.
- rs232_rx  in  1  serial input, asynchronous.
- rx_data  out  DATA_BITS  last received word.
- rx_valid  out  1  rx_data holds an unread word.
- rx_ready  in  1  consumer accepts rx_data.
- rx_parity_err  out  1  parity error flag for the current rx_data.
- rx_frame_err  out  1  framing error flag for the current rx_data (first stop bit sampled low).
- rx_overrun  out  1  one-cycle pulse when a completed frame is dropped.

Behaviour:
- Reset values:
  - rs232_tx=1, tx_ready=1.
  - rx_valid=0, rx_data=0, both error flags 0, rx_overrun=0.
  - All counters 0; both FSMs in IDLE.
  - Reset mid-frame aborts immediately; rs232_tx returns high asynchronously.
- Baud counters:
  - Each direction has its own counter, 0..CLK_DIV-1, reset to 0 on entering each bit.
  - TX advances a bit when the counter reaches CLK_DIV-1.
  - RX samples at count CLK_DIV/2 (integer division).
- TX FSM (IDLE, START, DATA, PARITY, STOP):
  - Transfer occurs on a cycle with tx_valid && tx_ready.
  - tx_data is captured into a shift register; tx_ready drops on the next edge.
  - rs232_tx goes 0 (start bit) in the same cycle tx_ready drops.
  - Then DATA_BITS data bits LSB first; then the parity bit if PARITY!=0 (odd: XOR of data inverted; even: XOR of data); then STOP_BITS high bits.
  - Each bit lasts exactly CLK_DIV cycles.
  - tx_ready returns high on the cycle after the last stop bit completes.
  - Frame length = (1+DATA_BITS+(PARITY?1:0)+STOP_BITS)*CLK_DIV cycles.
  - Back-to-back: a new transfer may be accepted on the first cycle tx_ready is high; no extra idle bit is inserted.
  - tx_valid while tx_ready=0 is ignored.
- RX front end:
  - rs232_rx passes through a 2-flop synchroniser; the synchronised value is used everywhere.
  - Falling-edge detection uses the synchronised value.
- RX FSM (IDLE, START, DATA, PARITY, STOP):
  - IDLE→START on a synchronised 1→0 transition.
  - At the START mid-sample: if the line is high, treat as a glitch and return to IDLE with no flags; otherwise continue.
  - Data bits are sampled at mid-bit and shifted in LSB first.
  - Parity is sampled and checked if enabled.
  - Only the first stop bit is sampled; the frame ends at that mid-sample and the FSM returns to IDLE.
  - RX therefore resynchronises on any later falling edge, including during the second stop bit.
- RX output:
  - At frame end, if rx_valid=0 or the same cycle has rx_ready=1: load rx_data and both error flags, and set rx_valid=1.
  - rx_valid clears on a cycle with rx_valid && rx_ready, unless a new word loads in that same cycle.
  - If rx_valid=1 and rx_ready=0 at frame end: the new word is discarded, rx_data and flags are unchanged, and rx_overrun pulses high for 1 cycle.
  - Error flags travel with their word and are valid only while rx_valid=1.
  - Error frames are still delivered: rx_data holds the sampled bits.
- TX and RX are fully independent; simultaneous activity has no interaction.

Test Plan:
- Reset: CLK_DIV=16, DATA_BITS=8, PARITY=0, STOP_BITS=1; assert rst_n=0 → rs232_tx=1, tx_ready=1, rx_valid=0; release and idle 100 cycles → outputs unchanged.
- TX 8N1: send 0xA5 with a one-cycle tx_valid → rs232_tx sequence 0,1,0,1,0,0,1,0,1,1 with 16 cycles per bit; tx_ready low for exactly 160 cycles; a second word accepted on the first ready cycle shows no gap.
- Loopback 8E1 and 7O2: tie rs232_tx to rs232_rx, hold rx_ready=1, send 0x3C (8E1) and 0x55 (7O2) → rx_data matches the sent word, rx_valid pulses 1 cycle, parity and frame errors 0; the 8E1 parity bit on the wire is 0.
- Error injection, 8E1: drive a frame with the wrong parity bit → rx_parity_err=1; drive stop=0 with data 0x00 → rx_frame_err=1 with rx_data=0x00.
- Overrun/glitch: rx_ready=0, receive 0x11 then 0x22 → rx_data stays 0x11, rx_overrun pulses once at the second frame end; a 3-cycle low pulse on rs232_rx → no rx_valid, no flags.
- Mid-frame reset: assert rst_n during TX bit 4 and during RX bit 4 → rs232_tx=1 immediately, rx_valid=0; a following clean frame is received correctly.
